// File: rtl/ctrl_pkg.sv
// Shared types for the accumulator-CPU sequencer: opcodes, phase encoding
// and the ALU-class opcode decode.
package ctrl_pkg;

   localparam int WAIT_W = 4;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_t;

   // Opcodes that read an operand from memory and load the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait-state down-counter: loads a wait length, counts down while
// enabled and flags done when it has reached zero.
module ctrl_wait_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] cnt;

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every flop samples the pre-edge value of its inputs.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (enable && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/seq_controller.sv
// Fetch/execute phase sequencer with opcode decode into datapath strobes,
// memory wait states, stall, sticky halt with resume and a retired counter.
module seq_controller
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [2:0]       opcode,
   input  logic             zero,
   input  logic             stall,
   input  logic             resume,
   output logic             mem_rd,
   output logic             load_ir,
   output logic             halt,
   output logic             inc_pc,
   output logic             load_ac,
   output logic             load_pc,
   output logic             mem_wr,
   output logic [3:0]       phase,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

   state_t  state, state_next;
   opcode_t op;
   logic    aluop;
   logic    wait_done, wait_load, wait_en;

   assign op    = opcode_t'(opcode);
   assign aluop = is_aluop(op);
   assign phase = state;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         state <= INST_ADDR;
      else
         state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      if (!stall) begin
         case (state)
            INST_ADDR:  state_next = INST_FETCH;
            INST_FETCH: if (wait_done) state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR:    state_next = (op == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   if (wait_done) state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE:      state_next = INST_ADDR;
            HALTED:     if (resume) state_next = INST_ADDR;
            default:    state_next = INST_ADDR;
         endcase
      end
   end

   // Counter reloads on the edge that enters a fetch phase and counts down
   // only while sitting in one; stall freezes it along with the state.
   assign wait_load = !stall && (state_next != state) &&
                      ((state_next == INST_FETCH) || (state_next == OP_FETCH));
   assign wait_en   = !stall && ((state == INST_FETCH) || (state == OP_FETCH));

   ctrl_wait_cnt #(.W(WAIT_W)) u_wait (
      .clk    (clk),
      .rst_   (rst_),
      .load   (wait_load),
      .enable (wait_en),
      .value  (WAIT_INIT),
      .done   (wait_done)
   );

   always_comb begin
      mem_rd  = 1'b0;
      load_ir = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      mem_wr  = 1'b0;
      case (state)
         INST_FETCH: mem_rd = 1'b1;
         INST_LOAD, IDLE: begin
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (op == HLT);
         end
         OP_FETCH: mem_rd = aluop;
         ALU_OP: begin
            mem_rd  = aluop;
            inc_pc  = (op == SKZ) && zero;
            load_pc = (op == JMP);
         end
         STORE: begin
            mem_rd  = aluop;
            load_ac = aluop;
            load_pc = (op == JMP);
            inc_pc  = (op == JMP);
            mem_wr  = (op == STO);
         end
         HALTED:  halt = 1'b1;
         default: ;
      endcase
   end

   // Retirement is the STORE -> INST_ADDR edge; a halted HLT never gets there.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         instr_count <= '0;
      else if (!stall && (state == STORE))
         instr_count <= instr_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench: a per-cycle vector table on a MEM_WAIT=0/CNT_W=4 instance,
// plus hand sequences for halt/resume, wrap, async reset, wait states, stall.
module tb_seq_controller;
   import ctrl_pkg::*;

   typedef struct {
      opcode_t    op;
      logic       z;
      state_t     ph;
      logic [6:0] str;   // {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
      int         cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: MEM_WAIT=0, CNT_W=4
   logic       rst_a = 1'b0, a_zero = 1'b0, a_stall = 1'b0, a_resume = 1'b0;
   logic [2:0] a_opcode = 3'd2;
   logic       a_rd, a_ir, a_halt, a_inc, a_ac, a_pc, a_wr;
   logic [3:0] a_phase, a_count;
   logic [6:0] a_str;
   assign a_str = {a_rd, a_ir, a_halt, a_inc, a_ac, a_pc, a_wr};

   seq_controller #(.MEM_WAIT(0), .CNT_W(4)) dut_a (
      .clk(clk), .rst_(rst_a), .opcode(a_opcode), .zero(a_zero),
      .stall(a_stall), .resume(a_resume),
      .mem_rd(a_rd), .load_ir(a_ir), .halt(a_halt), .inc_pc(a_inc),
      .load_ac(a_ac), .load_pc(a_pc), .mem_wr(a_wr),
      .phase(a_phase), .instr_count(a_count)
   );

   // Instance B: MEM_WAIT=3, CNT_W=16
   logic        rst_b = 1'b0, b_zero = 1'b0, b_stall = 1'b0, b_resume = 1'b0;
   logic [2:0]  b_opcode = 3'd5;
   logic        b_rd, b_ir, b_halt, b_inc, b_ac, b_pc, b_wr;
   logic [3:0]  b_phase;
   logic [15:0] b_count;

   seq_controller #(.MEM_WAIT(3), .CNT_W(16)) dut_b (
      .clk(clk), .rst_(rst_b), .opcode(b_opcode), .zero(b_zero),
      .stall(b_stall), .resume(b_resume),
      .mem_rd(b_rd), .load_ir(b_ir), .halt(b_halt), .inc_pc(b_inc),
      .load_ac(b_ac), .load_pc(b_pc), .mem_wr(b_wr),
      .phase(b_phase), .instr_count(b_count)
   );

   vec_t vecs[$];

   task automatic add(input opcode_t op, input logic z, input state_t ph,
                      input logic [6:0] str, input int cnt);
      vec_t v;
      v.op = op; v.z = z; v.ph = ph; v.str = str; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; the bench then acts just after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_cnt;
      int n;
      state_t b_seq [14];

      // ADD, zero=0
      add(ADD, 0, INST_ADDR,  7'b0000000, 0); add(ADD, 0, INST_FETCH, 7'b1000000, 0);
      add(ADD, 0, INST_LOAD,  7'b1100000, 0); add(ADD, 0, IDLE,       7'b1100000, 0);
      add(ADD, 0, OP_ADDR,    7'b0001000, 0); add(ADD, 0, OP_FETCH,   7'b1000000, 0);
      add(ADD, 0, ALU_OP,     7'b1000000, 0); add(ADD, 0, STORE,      7'b1000100, 0);
      // SKZ, zero=1: skip in ALU_OP
      add(SKZ, 1, INST_ADDR,  7'b0000000, 1); add(SKZ, 1, INST_FETCH, 7'b1000000, 1);
      add(SKZ, 1, INST_LOAD,  7'b1100000, 1); add(SKZ, 1, IDLE,       7'b1100000, 1);
      add(SKZ, 1, OP_ADDR,    7'b0001000, 1); add(SKZ, 1, OP_FETCH,   7'b0000000, 1);
      add(SKZ, 1, ALU_OP,     7'b0001000, 1); add(SKZ, 1, STORE,      7'b0000000, 1);
      // SKZ, zero=0: no skip
      add(SKZ, 0, INST_ADDR,  7'b0000000, 2); add(SKZ, 0, INST_FETCH, 7'b1000000, 2);
      add(SKZ, 0, INST_LOAD,  7'b1100000, 2); add(SKZ, 0, IDLE,       7'b1100000, 2);
      add(SKZ, 0, OP_ADDR,    7'b0001000, 2); add(SKZ, 0, OP_FETCH,   7'b0000000, 2);
      add(SKZ, 0, ALU_OP,     7'b0000000, 2); add(SKZ, 0, STORE,      7'b0000000, 2);
      // JMP
      add(JMP, 0, INST_ADDR,  7'b0000000, 3); add(JMP, 0, INST_FETCH, 7'b1000000, 3);
      add(JMP, 0, INST_LOAD,  7'b1100000, 3); add(JMP, 0, IDLE,       7'b1100000, 3);
      add(JMP, 0, OP_ADDR,    7'b0001000, 3); add(JMP, 0, OP_FETCH,   7'b0000000, 3);
      add(JMP, 0, ALU_OP,     7'b0000010, 3); add(JMP, 0, STORE,      7'b0001010, 3);
      // STO
      add(STO, 0, INST_ADDR,  7'b0000000, 4); add(STO, 0, INST_FETCH, 7'b1000000, 4);
      add(STO, 0, INST_LOAD,  7'b1100000, 4); add(STO, 0, IDLE,       7'b1100000, 4);
      add(STO, 0, OP_ADDR,    7'b0001000, 4); add(STO, 0, OP_FETCH,   7'b0000000, 4);
      add(STO, 0, ALU_OP,     7'b0000000, 4); add(STO, 0, STORE,      7'b0000001, 4);
      // HLT reaches HALTED after 5 cycles
      add(HLT, 0, INST_ADDR,  7'b0000000, 5); add(HLT, 0, INST_FETCH, 7'b1000000, 5);
      add(HLT, 0, INST_LOAD,  7'b1100000, 5); add(HLT, 0, IDLE,       7'b1100000, 5);
      add(HLT, 0, OP_ADDR,    7'b0011000, 5); add(HLT, 0, HALTED,     7'b0010000, 5);

      // Reset state, including across a clock edge with reset held
      #2;
      check("rst_phase_a", a_phase, INST_ADDR);
      check("rst_str_a", a_str, 7'b0000000);
      check("rst_cnt_a", a_count, 0);
      check("rst_phase_b", b_phase, INST_ADDR);
      check("rst_cnt_b", b_count, 0);
      step();
      check("rst_hold_phase_a", a_phase, INST_ADDR);
      check("rst_hold_str_a", a_str, 7'b0000000);

      rst_a = 1'b1;
      foreach (vecs[i]) begin
         a_opcode = vecs[i].op;
         a_zero   = vecs[i].z;
         #1;
         check($sformatf("vec%0d_phase", i), a_phase, vecs[i].ph);
         check($sformatf("vec%0d_strobes", i), a_str, vecs[i].str);
         check($sformatf("vec%0d_count", i), a_count, vecs[i].cnt);
         step();
      end

      // Halt is sticky for 20 idle cycles
      for (int i = 0; i < 20; i++) begin
         check("halted_phase", a_phase, HALTED);
         check("halted_halt", a_halt, 1'b1);
         step();
      end
      // Stall blocks resume
      a_stall = 1'b1; a_resume = 1'b1;
      step();
      check("stall_blocks_resume", a_phase, HALTED);
      a_stall = 1'b0;
      step();
      a_resume = 1'b0;
      check("resume_phase", a_phase, INST_ADDR);
      check("resume_count", a_count, 5);
      check("resume_str", a_str, 7'b0000000);

      // 16 ADDs from count 5 wrap 15 -> 0 and come back to 5
      a_opcode = ADD;
      exp_cnt = 5;
      for (int k = 0; k < 16; k++) begin
         for (int c = 0; c < 8; c++) step();
         exp_cnt = (exp_cnt + 1) % 16;
         check($sformatf("wrap_count_%0d", k), a_count, exp_cnt);
         check($sformatf("wrap_phase_%0d", k), a_phase, INST_ADDR);
      end

      // Asynchronous reset mid-ALU_OP
      for (int c = 0; c < 6; c++) step();
      check("pre_rst_phase", a_phase, ALU_OP);
      check("pre_rst_str", a_str, 7'b1000000);
      #1 rst_a = 1'b0;
      #1;
      check("async_rst_phase", a_phase, INST_ADDR);
      check("async_rst_str", a_str, 7'b0000000);
      check("async_rst_count", a_count, 0);
      step();
      rst_a = 1'b1;
      step();
      check("post_rst_phase", a_phase, INST_FETCH);

      // MEM_WAIT=3, LDA: 14-cycle instruction with 4-cycle fetch phases
      b_seq = '{INST_ADDR, INST_FETCH, INST_FETCH, INST_FETCH, INST_FETCH, INST_LOAD,
                IDLE, OP_ADDR, OP_FETCH, OP_FETCH, OP_FETCH, OP_FETCH, ALU_OP, STORE};
      rst_b = 1'b1;
      for (int c = 0; c < 14; c++) begin
         check($sformatf("lda_phase_c%0d", c), b_phase, b_seq[c]);
         if (b_seq[c] == OP_FETCH) check($sformatf("lda_rd_c%0d", c), b_rd, 1'b1);
         step();
      end
      check("lda_end_phase", b_phase, INST_ADDR);
      check("lda_end_count", b_count, 1);

      // Stall 5 cycles in the cnt=1 OP_FETCH cycle; two OP_FETCH cycles remain
      for (int c = 0; c < 10; c++) step();
      check("stall_entry_phase", b_phase, OP_FETCH);
      b_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_frozen_phase", b_phase, OP_FETCH);
         check("stall_frozen_rd", b_rd, 1'b1);
         step();
      end
      b_stall = 1'b0;
      n = 0;
      while (b_phase == OP_FETCH && n < 10) begin
         n++;
         step();
      end
      check("stall_remaining_fetch", n, 2);
      check("stall_after_phase", b_phase, ALU_OP);

      // Stall in STORE holds the retire count
      step();
      check("store_phase", b_phase, STORE);
      b_stall = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("store_stall_phase", b_phase, STORE);
      check("store_stall_count", b_count, 1);
      b_stall = 1'b0;
      step();
      check("store_release_phase", b_phase, INST_ADDR);
      check("store_release_count", b_count, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised instruction-sequencing controller for the 8-bit accumulator CPU; successor to the fixed 8-phase controller. It sequences the fetch/execute phases and decodes the 3-bit opcode into datapath strobes (memory read/write, IR/AC/PC loads, PC increment, halt). It adds programmable memory wait states, a stall input, a sticky halt with resume, and a retired-instruction counter. It sits between the instruction register and the PC/AC/memory control inputs.

## Interface
- MEM_WAIT, 0: extra cycles held in INST_FETCH and OP_FETCH for slow memory; legal range 0..15.
- CNT_W, 16: width of the retired-instruction counter.
- clk  in  1  clock; all state changes on its rising edge.
- rst_  in  1  reset; asynchronous, active-low.
- opcode  in  3  current IR opcode (ctrl_pkg::opcode_t).
- zero  in  1  accumulator-is-zero flag; sampled combinationally in ALU_OP only.
- stall  in  1  freeze: when high, state, wait counter and instr_count hold.
- resume  in  1  leaves HALTED; ignored in every other state.
- mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr  out  1 each  datapath strobes.
- phase  out  4  current state encoding (ctrl_pkg::state_t), for debug and bench.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- States, in order: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
- Main ring: INST_ADDR→INST_FETCH→INST_LOAD→IDLE→OP_ADDR→OP_FETCH→ALU_OP→STORE→INST_ADDR.
- OP_ADDR with opcode HLT goes to HALTED. HALTED with resume=1 goes to INST_ADDR; otherwise it stays.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are Moore/opcode decode. Any strobe not listed for a state is 0.
  - INST_FETCH: mem_rd.
  - INST_LOAD, IDLE: mem_rd, load_ir.
  - OP_ADDR: inc_pc; halt = (opcode==HLT).
  - OP_FETCH: mem_rd = ALUOP.
  - ALU_OP: mem_rd = ALUOP; inc_pc = (opcode==SKZ && zero); load_pc = (opcode==JMP).
  - STORE: mem_rd = ALUOP; load_ac = ALUOP; load_pc = inc_pc = (opcode==JMP); mem_wr = (opcode==STO).
  - HALTED: halt=1; all other strobes 0.
- Wait states: on entering INST_FETCH or OP_FETCH, the wait counter loads MEM_WAIT. The state holds, with outputs unchanged, until the counter reaches 0, then advances. MEM_WAIT=0 gives the plain 1-cycle phase.
- instr_count increments by 1 on the STORE→INST_ADDR transition. A HLT instruction does not count.
- Priority: rst_ > stall > normal sequencing. stall high in HALTED also blocks resume.
- Opcode values outside the enum do not exist (3-bit, fully decoded).

## Timing
- Reset (async assert, sync-safe deassert): phase=INST_ADDR, wait counter=0, instr_count=0.
- All strobes are 0 during and after reset until the first clock edge.
- First edge after rst_ deassert moves to INST_FETCH.
- One instruction takes 8 cycles + 2·MEM_WAIT with no stall.
- HLT takes 5 cycles + MEM_WAIT to reach HALTED.
- Strobes are combinational from the registered state, opcode and zero. They are valid the same cycle as phase. No output register stage.
- resume is sampled at the clock edge. A one-cycle pulse suffices; the first cycle after the pulse is INST_ADDR.
- stall asserted in a wait phase freezes the counter value. Countdown resumes where it stopped.
- rst_ asserted mid-instruction returns immediately to INST_ADDR with all strobes 0. instr_count clears.
- instr_count wrap: all-ones + 1 → 0, with no flag.

## Structure
- Package ctrl_pkg holds:
  - opcode_t: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - state_t: 4-bit, INST_ADDR=0 … STORE=7, HALTED=8.
  - An is_aluop() function.
- Sub-module ctrl_wait_cnt (load, enable, done) implements the MEM_WAIT countdown. The main FSM and decode stay in seq_controller.

## Test plan
- Reset, MEM_WAIT=0, opcode=ADD, zero=0: phase sequence 0,1,2,3,4,5,6,7,0. mem_rd and load_ac are high in STORE. instr_count=1 after 8 cycles.
- opcode=HLT: halt=1 in OP_ADDR, then phase=8 with halt held for 20 idle cycles. A resume pulse gives phase=0 on the next cycle. instr_count is unchanged.
- opcode=SKZ: zero=1 gives inc_pc=1 in ALU_OP. zero=0 gives inc_pc=0. opcode=JMP gives load_pc=1 in ALU_OP and STORE. opcode=STO gives mem_wr=1 only in STORE.
- MEM_WAIT=3, opcode=LDA: INST_FETCH and OP_FETCH each last 4 cycles. One instruction takes 14 cycles.
- stall=1 for 5 cycles during the second OP_FETCH wait cycle (MEM_WAIT=3): phase and strobes are frozen. Two more OP_FETCH cycles follow after release.
- CNT_W=4: 16 ADD instructions wrap instr_count 15→0. rst_ pulsed mid-ALU_OP gives phase=0, all strobes 0 and instr_count=0 asynchronously.
